nand_page_buffer: RTL
=====================

# nand_page_buffer

Single-page staging buffer between the DMA port and the NAND page-write sequencer. It accepts one page of 32-bit words from DMA, raises `buffer_ready` once the page is complete, and then streams the page out as bytes on a pull handshake to the sequencer's data phase. After the last byte it pulses `page_done` and rearms for the next page.

## Interface
- `PAGE_BYTES`, default 2048: page size in bytes. Must be a power of two and at least 8. The page holds `WORDS = PAGE_BYTES/4` words.
- `clk`  in  1  block clock (150 MHz domain).
- `reset`  in  1  asynchronous, active-low reset.
- `en_flash_write`  in  1  DMA word strobe.
- `data_ToFlash`  in  32  DMA word.
- `ready_write_flash`  out  1  buffer accepts a word this cycle.
- `abort`  in  1  synchronous clear to empty.
- `byte_req`  in  1  sequencer consumes the current byte.
- `byte_out`  out  8  current page byte.
- `byte_valid`  out  1  `byte_out` holds a valid byte.
- `buffer_ready`  out  1  full page loaded and drain in progress.
- `page_done`  out  1  one-cycle pulse after the last byte is consumed.
- `fill_cnt`  out  log2(WORDS)+1  words currently stored (10 bits at default).
- `err_overflow`  out  1  sticky: write attempted while not ready.
- `err_underflow`  out  1  sticky: `byte_req` while not valid.

## Operation
States:
- **FILL**
  - `ready_write_flash`=1.
  - `en_flash_write` stores `data_ToFlash` at `wr_ptr`, then `wr_ptr`+1 and `fill_cnt`+1.
  - When word `WORDS-1` is written, go to LOAD.
- **LOAD** (1 cycle)
  - Fetch word 0 into the output holding register. `byte_index`=0.
  - Go to DRAIN.
- **DRAIN**
  - `buffer_ready`=1, `byte_valid`=1.
  - `byte_out` = byte `byte_index[1:0]` of the held word, little-endian (index 0 → bits [7:0]).
  - `byte_req` advances `byte_index`.
  - The next word is prefetched, so `byte_valid` never drops across word boundaries. Back-to-back `byte_req` every cycle is sustained.
  - Consuming byte `PAGE_BYTES-1` goes to DONE.
- **DONE** (1 cycle)
  - `page_done`=1; `byte_valid`=`buffer_ready`=0.
  - `wr_ptr`, `fill_cnt`, `byte_index` cleared.
  - Go to FILL.

Rules:
- `ready_write_flash` is decoded from state: 1 only in FILL.
- `en_flash_write` outside FILL is dropped (no store) and sets `err_overflow`.
- `byte_req` outside DRAIN is ignored and sets `err_underflow`.
- `abort` from any state: next state FILL, all pointers and counters zero, both error flags cleared, no store that cycle. `abort` has priority over `en_flash_write` and `byte_req`.
- Arithmetic:
  - `wr_ptr` is log2(WORDS) bits; `byte_index` is log2(PAGE_BYTES) bits; both are unsigned.
  - Wrap to 0 is never used as a terminal condition. Terminal conditions are explicit compares against `WORDS-1` and `PAGE_BYTES-1`.
- `fill_cnt` reads `WORDS` in LOAD and DRAIN, and 0 after DONE.
- Storage contents are not reset; only pointers and state are.

## Timing
Reset (`reset`=0, asynchronously):
- State goes to FILL.
- Outputs: `ready_write_flash`=1; `byte_out`=0x00; `byte_valid`, `buffer_ready`, `page_done`, `err_overflow`, `err_underflow` = 0; `fill_cnt`=0.

Edge-by-edge:
- Write accepted at edge k: `fill_cnt` increments after edge k.
- Last write at edge N: `ready_write_flash`=0 after N, LOAD during N→N+1, `buffer_ready`=`byte_valid`=1 after N+1 with byte 0 on `byte_out`.
- `byte_req` sampled at edge m: the next byte appears after m.
- Last `byte_req` at edge M: `page_done`=1 for the cycle after M; FILL with `ready_write_flash`=1 after M+1.
- Minimum page turnaround: `WORDS` + `PAGE_BYTES` + 2 cycles.
- Reset asserted mid-operation: immediate return to reset values. A partial page is discarded and no `page_done` is issued.

## Test plan
- Write 512 words, word i = {4i+3, 4i+2, 4i+1, 4i} (8-bit fields, mod 256). Pull with `byte_req` held high. Required: bytes 0x00,0x01,…,0xFF,0x00,… with no `byte_valid` gap; `page_done` one cycle after the 2048th pull; `ready_write_flash`=1 one cycle later.
- Pull with `byte_req` toggling 1/0 randomly. Required: identical byte sequence, with each byte held stable while `byte_req`=0.
- Stop at 100 words, then pulse `abort`. Required: `fill_cnt`=0 next cycle, no `buffer_ready`. A following full page drains correctly.
- Fill a page, then strobe `en_flash_write` with 0xDEADBEEF during DRAIN. Required: `err_overflow`=1 and the drained data is unchanged. Separately, `byte_req` in FILL sets `err_underflow`=1. `abort` clears both.
- Drive `reset` low at byte 1000 of DRAIN. Required: all outputs at reset values asynchronously. The next page starts from word 0.
- `PAGE_BYTES`=16: 4 words in, 16 bytes out. Required: LOAD/DONE timing exactly as in Timing, with `fill_cnt` 3 bits wide.

Source files
------------

// File: rtl/nand_page_buffer_if.sv
// Bus bundle between the page buffer, the DMA write port and the NAND
// sequencer's data phase. The page buffer takes the slave view.
interface nand_page_buffer_if #(
    parameter int PAGE_BYTES = 2048
);
    localparam int CW = $clog2(PAGE_BYTES / 4) + 1;

    logic          en_flash_write;
    logic [31:0]   data_ToFlash;
    logic          ready_write_flash;
    logic          abort;
    logic          byte_req;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          buffer_ready;
    logic          page_done;
    logic [CW-1:0] fill_cnt;
    logic          err_overflow;
    logic          err_underflow;

    modport slave (
        input  en_flash_write, data_ToFlash, abort, byte_req,
        output ready_write_flash, byte_out, byte_valid, buffer_ready,
               page_done, fill_cnt, err_overflow, err_underflow
    );

    modport master (
        output en_flash_write, data_ToFlash, abort, byte_req,
        input  ready_write_flash, byte_out, byte_valid, buffer_ready,
               page_done, fill_cnt, err_overflow, err_underflow
    );
endinterface

// File: rtl/nand_page_buffer.sv
// Single-page staging buffer: collects one page of 32-bit DMA words, then
// streams it out as little-endian bytes on a pull handshake to the NAND
// page-write sequencer. PAGE_BYTES must be a power of two and at least 8.
//
// state | meaning
// FILL  | accepting DMA words until word WORDS-1 is stored
// LOAD  | one cycle: word 0 into the holding register, word 1 prefetched
// DRAIN | bytes presented on byte_out, advanced by byte_req
// DONE  | one cycle: page_done pulse, pointers cleared on exit
module nand_page_buffer #(
    parameter int PAGE_BYTES = 2048
) (
    input  logic                clk,
    input  logic                reset,
    nand_page_buffer_if.slave   bus
);
    localparam int WORDS = PAGE_BYTES / 4;
    localparam int AW    = $clog2(WORDS);
    localparam int BW    = $clog2(PAGE_BYTES);
    localparam int CW    = AW + 1;

    localparam logic [AW-1:0] LAST_WORD   = AW'(WORDS - 1);
    localparam logic [BW-1:0] LAST_BYTE   = BW'(PAGE_BYTES - 1);
    localparam logic [AW-1:0] FIRST_WORD  = '0;
    localparam logic [AW-1:0] SECOND_WORD = AW'(1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [31:0]   mem [WORDS];
    logic [AW-1:0] wr_ptr;
    logic [BW-1:0] byte_index;
    logic [CW-1:0] fill_cnt;
    logic [31:0]   hold_word;
    logic [31:0]   next_word;
    logic [AW-1:0] rd_word;
    logic [AW-1:0] pre_addr;
    logic [7:0]    byte_sel;
    logic          err_overflow;
    logic          err_underflow;

    logic          do_store;
    logic          do_pull;
    logic          clr_ptrs;

    assign rd_word = byte_index[BW-1:2];

    // Next-state decode; abort overrides any store or pull in the same cycle.
    always_comb begin
        state_nxt = state;
        do_store  = 1'b0;
        do_pull   = 1'b0;
        clr_ptrs  = 1'b0;
        if (bus.abort) begin
            state_nxt = FILL;
            clr_ptrs  = 1'b1;
        end else begin
            case (state)
                FILL: begin
                    if (bus.en_flash_write) begin
                        do_store = 1'b1;
                        if (wr_ptr == LAST_WORD) state_nxt = LOAD;
                    end
                end
                LOAD: state_nxt = DRAIN;
                DRAIN: begin
                    if (bus.byte_req) begin
                        do_pull = 1'b1;
                        if (byte_index == LAST_BYTE) state_nxt = DONE;
                    end
                end
                DONE: begin
                    clr_ptrs  = 1'b1;
                    state_nxt = FILL;
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FILL;
        else        state <= state_nxt;
    end

    // Page storage; contents survive reset, only pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_store) mem[wr_ptr] <= bus.data_ToFlash;
    end

    // Prefetch the word after the one being drained so the byte stream has
    // no bubble at word boundaries; the address wraps harmlessly on the last word.
    assign pre_addr = (state == DRAIN) ? AW'(rd_word + SECOND_WORD) : SECOND_WORD;

    // Read path: synchronous reads into the prefetch and holding registers.
    always_ff @(posedge clk) begin
        next_word <= mem[pre_addr];
        if (state == LOAD)
            hold_word <= mem[FIRST_WORD];
        else if (do_pull && (byte_index[1:0] == 2'b11))
            hold_word <= next_word;
    end

    // Write pointer, fill count and byte index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            byte_index <= '0;
        end else if (clr_ptrs) begin
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            byte_index <= '0;
        end else begin
            if (do_store) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fill_cnt <= fill_cnt + CW'(1);
            end
            if (state == LOAD)
                byte_index <= '0;
            else if (do_pull)
                byte_index <= byte_index + BW'(1);
        end
    end

    // Sticky protocol-error flags, cleared only by abort or reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (bus.abort) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (bus.en_flash_write && (state != FILL)) err_overflow  <= 1'b1;
            if (bus.byte_req && (state != DRAIN))      err_underflow <= 1'b1;
        end
    end

    // Little-endian byte select out of the holding register.
    always_comb begin
        byte_sel = 8'h00;
        case (byte_index[1:0])
            2'd0: byte_sel = hold_word[7:0];
            2'd1: byte_sel = hold_word[15:8];
            2'd2: byte_sel = hold_word[23:16];
            2'd3: byte_sel = hold_word[31:24];
            default: byte_sel = 8'h00;
        endcase
    end

    assign bus.ready_write_flash = (state == FILL);
    assign bus.byte_valid        = (state == DRAIN);
    assign bus.buffer_ready      = (state == DRAIN);
    assign bus.page_done         = (state == DONE);
    assign bus.byte_out          = (state == DRAIN) ? byte_sel : 8'h00;
    assign bus.fill_cnt          = fill_cnt;
    assign bus.err_overflow      = err_overflow;
    assign bus.err_underflow     = err_underflow;
endmodule
